// File: rtl/hex_scan_ctrl_if.sv
// hex_scan_ctrl_if: write/commit bus into the shadow digit buffer of hex_scan_ctrl.
// The master drives digit writes and commit requests; the slave reports wr_ready.
interface hex_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed 8-digit seven-segment scan controller.
// Each digit gets a SHOW phase of DIV cycles followed by an all-off GUARD phase
// of GUARD cycles. Digits are written into a shadow buffer and copied into the
// displayed (active) buffer only at a frame boundary, so a frame never mixes
// old and new digits.
// Optional feature: define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_scan_ctrl_if.slave        wr_bus,
    input  logic [7:0]            blank,
    output logic [6:0]            hex,
    output logic [7:0]            hex_on,
    output logic [2:0]            digit_idx,
    output logic                  frame_done
);

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    // Active-low segment decode {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [2:0]  digit_idx_r;
    logic [6:0]  hex_r;
    logic [7:0]  hex_on_r;
    logic        frame_done_r;
    logic        commit_pending_r;
    logic [3:0]  shadow_r [8];
    logic [3:0]  active_r [8];

    logic        boundary_s;
    logic [7:0]  lz_blank_s;
    logic [3:0]  cur_digit_s;
    logic [6:0]  disp_hex_s;
    logic [7:0]  disp_on_s;
`ifdef HEX_SCAN_LZB_EN
    logic        lz_run_s;
`endif

    assign hex             = hex_r;
    assign hex_on          = hex_on_r;
    assign digit_idx       = digit_idx_r;
    assign frame_done      = frame_done_r;
    assign wr_bus.wr_ready = ~commit_pending_r;

    // Frame boundary: the last GUARD cycle of digit 7.
    always_comb begin
        boundary_s = (state_r == ST_GUARD) && (cnt_r == GUARD_LAST) && (digit_idx_r == 3'd7);
    end

    // Leading-zero mask: a digit above 0 is dark when it and all digits above it are zero.
    always_comb begin
        lz_blank_s = 8'h00;
`ifdef HEX_SCAN_LZB_EN
        lz_run_s = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            lz_run_s      = lz_run_s & (active_r[i] == 4'h0);
            lz_blank_s[i] = lz_run_s;
        end
`endif
    end

    // Next display pattern from the current scan position and active buffer.
    always_comb begin
        cur_digit_s = active_r[digit_idx_r];
        if ((state_r == ST_SHOW) && !blank[digit_idx_r] && !lz_blank_s[digit_idx_r]) begin
            disp_on_s  = ~(8'b0000_0001 << digit_idx_r);
            disp_hex_s = seg_decode(cur_digit_s);
        end else begin
            disp_on_s  = 8'hFF;
            disp_hex_s = 7'b1111111;
        end
    end

    // Scan FSM: SHOW/GUARD phase sequencing plus the registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SHOW;
            cnt_r        <= 16'd0;
            digit_idx_r  <= 3'd0;
            hex_r        <= 7'b1111111;
            hex_on_r     <= 8'hFF;
            frame_done_r <= 1'b0;
        end else begin
            hex_r        <= disp_hex_s;
            hex_on_r     <= disp_on_s;
            frame_done_r <= boundary_s;
            case (state_r)
                ST_SHOW: begin
                    if (cnt_r == DIV_LAST) begin
                        state_r <= ST_GUARD;
                        cnt_r   <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_r == GUARD_LAST) begin
                        state_r     <= ST_SHOW;
                        cnt_r       <= 16'd0;
                        digit_idx_r <= digit_idx_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r     <= ST_SHOW;
                    cnt_r       <= 16'd0;
                    digit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    // Shadow writes, commit request tracking and the boundary copy to the active buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pending_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= 4'h0;
                active_r[i] <= 4'h0;
            end
        end else begin
            // Writes are accepted only while no commit is waiting, so the
            // shadow buffer is frozen between commit and the boundary copy.
            if (wr_bus.wr_valid && !commit_pending_r) begin
                shadow_r[wr_bus.wr_addr] <= wr_bus.wr_data;
            end else begin
                shadow_r[wr_bus.wr_addr] <= shadow_r[wr_bus.wr_addr];
            end
            if (boundary_s && commit_pending_r) begin
                commit_pending_r <= 1'b0;
                for (int i = 0; i < 8; i++) begin
                    active_r[i] <= shadow_r[i];
                end
            end else if (wr_bus.commit && !commit_pending_r) begin
                commit_pending_r <= 1'b1;
            end else begin
                commit_pending_r <= commit_pending_r;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed bench for hex_scan_ctrl with DIV=4, GUARD=2.
// A frame-position model predicts every output each cycle; pinned literal
// checks at chosen cycles anchor the model to hand-computed values.
module tb_hex_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GUARD = 2;
    localparam int SLOT  = DIV + GUARD;
    localparam int FRAME = 8 * SLOT;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEG_M [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk;
    logic       rst;
    logic [7:0] blank;
    logic [6:0] hex;
    logic [7:0] hex_on;
    logic [2:0] digit_idx;
    logic       frame_done;

    hex_scan_ctrl_if bus ();

    hex_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_bus     (bus),
        .blank      (blank),
        .hex        (hex),
        .hex_on     (hex_on),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset release, shadow/active digits, pending flag.
    int         n_m = 0;
    bit         model_ok = 1'b0;
    bit         pending_m;
    logic [3:0] shadow_m [8];
    logic [3:0] active_m [8];
    logic [6:0] e_hex;
    logic [7:0] e_on;
    logic [2:0] e_idx;
    logic       e_fd;

    function automatic bit lz_m(int d);
        bit z = 1'b1;
        if (!LZB || d == 0) return 1'b0;
        for (int j = d; j < 8; j++) begin
            if (active_m[j] != 4'h0) z = 1'b0;
        end
        return z;
    endfunction

    function automatic int dig_m(int n_prev);
        return (n_prev % FRAME) / SLOT;
    endfunction

    function automatic bit lit_m(int n_prev, logic [7:0] blk);
        int d = dig_m(n_prev);
        return ((n_prev % FRAME) % SLOT < DIV) && !blk[d] && !lz_m(d);
    endfunction

    // Behavioural model: expected outputs for the cycle after this edge.
    always @(posedge clk) begin
        if (rst) begin
            n_m       <= 0;
            model_ok  <= 1'b1;
            pending_m <= 1'b0;
            e_hex     <= 7'h7F;
            e_on      <= 8'hFF;
            e_idx     <= 3'd0;
            e_fd      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_m[i] <= 4'h0;
                active_m[i] <= 4'h0;
            end
        end else begin
            n_m   <= n_m + 1;
            e_fd  <= ((n_m + 1) % FRAME) == 0;
            e_idx <= 3'(((n_m + 1) / SLOT) % 8);
            e_on  <= lit_m(n_m, blank) ? 8'(~(8'd1 << dig_m(n_m))) : 8'hFF;
            e_hex <= lit_m(n_m, blank) ? SEG_M[active_m[dig_m(n_m)]] : 7'h7F;
            if (bus.wr_valid && !pending_m) shadow_m[bus.wr_addr] <= bus.wr_data;
            if ((((n_m + 1) % FRAME) == 0) && pending_m) begin
                pending_m <= 1'b0;
                for (int i = 0; i < 8; i++) active_m[i] <= shadow_m[i];
            end else if (bus.commit && !pending_m) begin
                pending_m <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("hex",        32'(hex),          32'(e_hex));
            check("hex_on",     32'(hex_on),       32'(e_on));
            check("digit_idx",  32'(digit_idx),    32'(e_idx));
            check("frame_done", 32'(frame_done),   32'(e_fd));
            check("wr_ready",   32'(bus.wr_ready), 32'(!pending_m));
        end
    end

    // Wait (on falling edges) until the model has counted n edges since reset release.
    task automatic go_to(input int n);
        int budget = 0;
        while (n_m < n && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (n_m < n) begin
            bad++;
            $display("FAIL go_to got=%0d exp=%0d", n_m, n);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [3:0] d, input logic c);
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.commit   = c;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        blank        = 8'h00;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 4'h0;
        bus.commit   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hex",   32'(hex),          32'h7F);
        check("rst_on",    32'(hex_on),       32'hFF);
        check("rst_ready", 32'(bus.wr_ready), 32'h1);
        rst = 1'b0;

        // First digit slot: 4 cycles lit, 2 dark, then digit 1.
        for (int k = 1; k <= 4; k++) begin
            go_to(k);
            check("d0_on",  32'(hex_on), 32'hFE);
            check("d0_hex", 32'(hex),    32'b1000000);
        end
        go_to(5);
        check("g0_on", 32'(hex_on), 32'hFF);
        go_to(6);
        check("g0_hex", 32'(hex), 32'h7F);
        go_to(7);
        check("d1_on", 32'(hex_on), 32'hFD);

        // Write digit 3 <- A, commit mid-frame, ignored write while pending.
        go_to(9);
        drive(1'b1, 3'd3, 4'hA, 1'b0);
        go_to(19);
        check("f1_d3_hex", 32'(hex),    32'b1000000);
        check("f1_d3_on",  32'(hex_on), 32'hF7);
        drive(1'b0, 3'd0, 4'h0, 1'b1);
        go_to(21);
        check("pend_ready", 32'(bus.wr_ready), 32'h0);
        go_to(24);
        drive(1'b1, 3'd0, 4'h5, 1'b0);
        go_to(48);
        check("fd_48",  32'(frame_done), 32'h1);
        check("idx_48", 32'(digit_idx),  32'h0);
        go_to(49);
        check("f2_d0_hex",  32'(hex),          32'b1000000);
        check("f2_ready",   32'(bus.wr_ready), 32'h1);
        go_to(67);
        check("f2_d3_hex", 32'(hex),    32'b0001000);
        check("f2_d3_on",  32'(hex_on), 32'hF7);

        // Write + commit together, then a redundant commit while pending.
        go_to(70);
        drive(1'b1, 3'd7, 4'hF, 1'b1);
        go_to(75);
        drive(1'b0, 3'd0, 4'h0, 1'b1);
        go_to(77);
        check("pend2_ready", 32'(bus.wr_ready), 32'h0);
        go_to(139);
        check("f3_d7_hex", 32'(hex),    32'b0001110);
        check("f3_d7_on",  32'(hex_on), 32'h7F);

        // Blank digit 0; commit in the boundary cycle itself lands one frame later.
        go_to(143);
        blank = 8'h01;
        go_to(145);
        check("blank_on", 32'(hex_on), 32'hFF);
        go_to(150);
        drive(1'b1, 3'd1, 4'h2, 1'b0);
        go_to(191);
        drive(1'b0, 3'd0, 4'h0, 1'b1);
        check("fd_192",    32'(frame_done),   32'h1);
        check("ready_192", 32'(bus.wr_ready), 32'h0);
        go_to(199);
        check("f5_d1_hex", 32'(hex),    32'b1000000);
        check("f5_d1_on",  32'(hex_on), 32'hFD);
        go_to(200);
        blank = 8'h00;
        go_to(247);
        check("f6_d1_hex", 32'(hex), 32'b0100100);

        // Active buffer 0000_0120 for leading-zero behaviour.
        go_to(250);
        drive(1'b1, 3'd7, 4'h0, 1'b0);
        go_to(252);
        drive(1'b1, 3'd3, 4'h0, 1'b0);
        go_to(254);
        drive(1'b1, 3'd2, 4'h1, 1'b0);
        go_to(256);
        drive(1'b0, 3'd0, 4'h0, 1'b1);
        go_to(301);
        check("lz_d2_hex", 32'(hex),    32'b1111001);
        check("lz_d2_on",  32'(hex_on), 32'hFB);
        go_to(307);
        check("lz_d3_on", 32'(hex_on), LZB ? 32'hFF : 32'hF7);

        // Reset mid-frame with a commit pending: commit is discarded.
        go_to(310);
        drive(1'b1, 3'd0, 4'h9, 1'b1);
        go_to(320);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_hex",   32'(hex),          32'h7F);
        check("mrst_on",    32'(hex_on),       32'hFF);
        check("mrst_fd",    32'(frame_done),   32'h0);
        check("mrst_ready", 32'(bus.wr_ready), 32'h1);
        check("mrst_idx",   32'(digit_idx),    32'h0);
        rst = 1'b0;
        go_to(1);
        check("pr_d0_hex", 32'(hex),    32'b1000000);
        check("pr_d0_on",  32'(hex_on), 32'hFE);
        go_to(49);
        check("pr2_d0_hex", 32'(hex), 32'b1000000);
        go_to(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, SHOW-phase length in clk cycles per digit (range 2..65535).
REQ-002 Parameter GUARD, default 16, all-off anti-ghosting interval in clk cycles between digits (range 1..65535).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_valid  input  1  write request into shadow digit buffer.
REQ-006 wr_ready  output  1  shadow buffer can accept a write.
REQ-007 wr_addr  input  3  digit index 0..7 (0 = rightmost).
REQ-008 wr_data  input  4  hex nibble for that digit.
REQ-009 commit  input  1  single-cycle request to copy shadow to active buffer at next frame boundary.
REQ-010 blank  input  8  per-digit force-blank mask, bit i blanks digit i.
REQ-011 hex  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 hex_on  output  8  active-low digit enables, bit i = digit i.
REQ-013 digit_idx  output  3  digit currently scanned.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 FSM states SHOW and GUARD; SHOW lasts exactly DIV cycles, then GUARD lasts exactly GUARD cycles, then SHOW of digit_idx+1 (mod 8).
REQ-016 Phase counter 16 bits, cleared on every state transition; no other wrap.
REQ-017 Frame boundary = final GUARD cycle of digit 7; on that edge digit_idx wraps 7->0 and frame_done pulses high for exactly one cycle.
REQ-018 hex and hex_on are registered and reflect FSM state and active buffer with one cycle of latency.
REQ-019 In SHOW for digit i, not blanked: hex_on = ~(8'b1 << i), hex = seg(active[i]).
REQ-020 In GUARD, or digit blanked: hex_on = 8'hFF, hex = 7'b1111111.
REQ-021 Seg table is the team's standard 0-F active-low decode (0 -> 1000000, 1 -> 1111001, 8 -> 0000000, A -> 0001000, F -> 0001110).
REQ-022 Write handshake: transfer when wr_valid && wr_ready; shadow[wr_addr] <= wr_data on that edge; wr_valid while wr_ready low is ignored, not queued.
REQ-023 commit sets commit_pending; wr_ready = !commit_pending.
REQ-024 At frame boundary with commit_pending set: active <= shadow (all 8 digits), commit_pending cleared, wr_ready high next cycle.
REQ-025 Write and commit in the same cycle with wr_ready high: the write lands in shadow and is included in the commit.
REQ-026 commit while commit_pending already set has no effect.
REQ-027 commit asserted in the frame-boundary cycle itself is applied at the following boundary.
REQ-028 Active buffer changes only at frame boundaries; a displayed frame never mixes old and new digits.

Reset
REQ-029 On rst high at a clock edge: state = SHOW, digit_idx = 0, counter = 0, shadow and active buffers = 0, commit_pending = 0.
REQ-030 Output reset values: hex = 7'b1111111, hex_on = 8'hFF, frame_done = 0, wr_ready = 1.
REQ-031 Reset mid-frame, or during a pending commit, discards the pending commit; the first post-reset frame displays all zeros.

Configuration
REQ-032 Macro HEX_SCAN_LZB_EN enables leading-zero blanking.
REQ-033 With HEX_SCAN_LZB_EN defined: digit i (i >= 1) is blanked when active[i] and every active digit above i are 0; digit 0 is never blanked by this rule; the blank input still applies.
REQ-034 Without HEX_SCAN_LZB_EN: only the blank input blanks digits.

Verification (DIV=4, GUARD=2, frame = 48 cycles)
REQ-035 Release rst -> from cycle 1: hex_on=FE, hex=1000000 for 4 cycles, then FF/7F for 2 cycles, then hex_on=FD.
REQ-036 Write addr 3 <- 4'hA, then commit mid-frame -> wr_ready low until boundary; from the next frame digit 3 shows 0001000 with hex_on=F7; earlier frames show 0.
REQ-037 Write while wr_ready low (addr 0 <- 5) -> ignored; after commit, digit 0 still shows its committed value.
REQ-038 Write addr 7 <- F and commit in the same cycle -> digit 7 shows 0001110 after the boundary; second commit during pending -> no extra effect.
REQ-039 blank=8'h01 -> digit 0 slot shows hex_on=FF; frame_done pulses once every 48 cycles.
REQ-040 Assert rst mid-frame with commit pending -> next cycle reset values; no commit applied; with HEX_SCAN_LZB_EN and active=0000_0120, only digits 0-2 are lit.
